// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Shares the single write port of the register bank between the
//             ALU writeback (req0) and the load writeback (req1). Arbitration
//             is round-robin, and the winning write is registered onto the
//             bank write port. The module also keeps a busy scoreboard of
//             reserved destination registers and a saturating stall counter.
//  Ports    : clk, reset            - clock / async active-high reset
//             req0*/req1*           - valid/ready writeback requesters
//             reserveValid/Addr     - destination reservation from issue
//             regWrite/writeAddr/   - registered bank write port
//             writeData
//             busy                  - pending-write bitmap, bit 0 always 0
//             conflict              - sticky double-reservation flag
//             stallCount            - saturating lost-arbitration counter
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 5,
   parameter int STALL_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req0Valid,
   output logic                       req0Ready,
   input  logic [ADDR_WIDTH-1:0]      req0Addr,
   input  logic [DATA_WIDTH-1:0]      req0Data,
   input  logic                       req1Valid,
   output logic                       req1Ready,
   input  logic [ADDR_WIDTH-1:0]      req1Addr,
   input  logic [DATA_WIDTH-1:0]      req1Data,
   input  logic                       reserveValid,
   input  logic [ADDR_WIDTH-1:0]      reserveAddr,
   output logic                       regWrite,
   output logic [ADDR_WIDTH-1:0]      writeAddr,
   output logic [DATA_WIDTH-1:0]      writeData,
   output logic [(2**ADDR_WIDTH)-1:0] busy,
   output logic                       conflict,
   output logic [STALL_CNT_WIDTH-1:0] stallCount
);

   localparam int c_NUM_REGS = 2**ADDR_WIDTH;
   localparam logic [STALL_CNT_WIDTH-1:0] c_STALL_MAX = {STALL_CNT_WIDTH{1'b1}};

   // prio = 0 prefers req0 on contention, prio = 1 prefers req1
   logic                   r_prio;
   logic                   w_grant0;
   logic                   w_grant1;
   logic                   w_accept;
   logic [ADDR_WIDTH-1:0]  w_win_addr;
   logic [DATA_WIDTH-1:0]  w_win_data;
   logic                   w_clear_hit;
   logic                   w_conflict_hit;
   logic [c_NUM_REGS-1:0]  w_busy_next;

   // ---------------------------------------------------------------------
   // Arbitration: a lone requester always wins; on contention prio decides.
   // ---------------------------------------------------------------------
   assign w_grant0   = req0Valid && (!req1Valid || !r_prio);
   assign w_grant1   = req1Valid && (!req0Valid ||  r_prio);
   assign w_accept   = w_grant0 || w_grant1;
   assign w_win_addr = w_grant0 ? req0Addr : req1Addr;
   assign w_win_data = w_grant0 ? req0Data : req1Data;

   assign req0Ready  = w_grant0;
   assign req1Ready  = w_grant1;

   // The write currently on the bank port completes at this edge, so a
   // reservation of that same address is a fresh one, not a conflict.
   assign w_clear_hit    = regWrite && (writeAddr == reserveAddr);
   assign w_conflict_hit = reserveValid && busy[reserveAddr] && !w_clear_hit;

   // Clear first, then set, so a reservation on the completing address wins.
   always_comb begin
      w_busy_next = busy;
      if (regWrite) begin
         w_busy_next[writeAddr] = 1'b0;
      end
      if (reserveValid) begin
         w_busy_next[reserveAddr] = 1'b1;
      end
      w_busy_next[0] = 1'b0;
   end

   // ---------------------------------------------------------------------
   // Write output stage, priority pointer, scoreboard and counters.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prio     <= 1'b0;
         regWrite   <= 1'b0;
         writeAddr  <= '0;
         writeData  <= '0;
         busy       <= '0;
         conflict   <= 1'b0;
         stallCount <= '0;
      end else begin
         if (w_accept) begin
            // Next contention favours whoever was not granted now.
            r_prio    <= w_grant0;
            writeAddr <= w_win_addr;
            writeData <= w_win_data;
            // Register 0 is hardwired: accept the request, drop the write.
            regWrite  <= (w_win_addr != '0);
         end else begin
            regWrite  <= 1'b0;
         end

         busy <= w_busy_next;

         if (w_conflict_hit) begin
            conflict <= 1'b1;
         end

         if (req0Valid && req1Valid && (stallCount != c_STALL_MAX)) begin
            stallCount <= stallCount + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Self-checking bench for regfile_wb_arbiter. Stimulus pushes the
//             expected bank writes into a queue; a monitor pops and compares
//             them whenever regWrite is presented. Directed checks cover
//             ready handshakes, scoreboard, conflict and stall counting.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int SW = 4;   // narrow counter so saturation is reachable

   logic          clk;
   logic          reset;
   logic          req0Valid, req1Valid, reserveValid;
   logic          req0Ready, req1Ready;
   logic [AW-1:0] req0Addr, req1Addr, reserveAddr;
   logic [DW-1:0] req0Data, req1Data;
   logic          regWrite;
   logic [AW-1:0] writeAddr;
   logic [DW-1:0] writeData;
   logic [31:0]   busy;
   logic          conflict;
   logic [SW-1:0] stallCount;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;
   wr_t exp_q[$];

   logic     m_prio  = 1'b0;
   int       m_stall = 0;

   regfile_wb_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STALL_CNT_WIDTH(SW)
   ) dut (
      .clk(clk), .reset(reset),
      .req0Valid(req0Valid), .req0Ready(req0Ready), .req0Addr(req0Addr), .req0Data(req0Data),
      .req1Valid(req1Valid), .req1Ready(req1Ready), .req1Addr(req1Addr), .req1Data(req1Data),
      .reserveValid(reserveValid), .reserveAddr(reserveAddr),
      .regWrite(regWrite), .writeAddr(writeAddr), .writeData(writeData),
      .busy(busy), .conflict(conflict), .stallCount(stallCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every presented bank write must match the oldest expected one.
   always @(negedge clk) begin
      if (!reset && regWrite) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr=%0d data=0x%0h required none", writeAddr, writeData);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", 64'(writeAddr), 64'(e.addr));
            check("write_data", 64'(writeData), 64'(e.data));
         end
      end
   end

   // One cycle of stimulus: inputs applied just after a rising edge, ready
   // checked at the falling edge, returns just after the next rising edge.
   task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic rv, input logic [AW-1:0] ra);
      logic e0, e1;
      wr_t  w;
      req0Valid = v0; req0Addr = a0; req0Data = d0;
      req1Valid = v1; req1Addr = a1; req1Data = d1;
      reserveValid = rv; reserveAddr = ra;
      @(negedge clk);
      e0 = v0 && (!v1 || !m_prio);
      e1 = v1 && (!v0 ||  m_prio);
      check("req0Ready", 64'(req0Ready), 64'(e0));
      check("req1Ready", 64'(req1Ready), 64'(e1));
      if (e0 || e1) begin
         w.addr = e0 ? a0 : a1;
         w.data = e0 ? d0 : d1;
         if (w.addr != 0) exp_q.push_back(w);
         m_prio = e0;
      end
      if (v0 && v1 && m_stall < 15) m_stall++;
      @(posedge clk);
      #1;
      req0Valid = 1'b0; req1Valid = 1'b0; reserveValid = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   initial begin
      reset = 1'b1;
      req0Valid = 0; req0Addr = '0; req0Data = '0;
      req1Valid = 0; req1Addr = '0; req1Data = '0;
      reserveValid = 0; reserveAddr = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_regWrite",   64'(regWrite),   64'd0);
      check("rst_writeAddr",  64'(writeAddr),  64'd0);
      check("rst_writeData",  64'(writeData),  64'd0);
      check("rst_busy",       64'(busy),       64'd0);
      check("rst_conflict",   64'(conflict),   64'd0);
      check("rst_stallCount", 64'(stallCount), 64'd0);
      reset = 1'b0;

      // Contention: grants alternate req0, req1, req0, req1
      for (int i = 0; i < 4; i++) step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, '0);
      check("stall_after_4", 64'(stallCount), 64'd4);

      // Zero register: accepted, no write, priority still moves to req1
      step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, 1'b0, '0);
      @(negedge clk);
      check("zero_no_write", 64'(regWrite), 64'd0);
      @(posedge clk); #1;
      step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b0, '0);
      check("zero_then_req1", 64'(writeAddr), 64'd10);
      step(1'b1, 5'd9, 32'h99, 1'b0, '0, '0, 1'b0, '0);

      // Single requester, 1-cycle latency then idle
      step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, '0);
      check("single_regWrite",  64'(regWrite),  64'd1);
      check("single_writeAddr", 64'(writeAddr), 64'd5);
      check("single_writeData", 64'(writeData), 64'hDEAD_BEEF);
      idle();
      check("single_idle", 64'(regWrite), 64'd0);

      // Sustained contention drives the counter into saturation
      for (int i = 0; i < 12; i++) step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, '0);
      check("stall_model", 64'(stallCount), 64'(m_stall));
      check("stall_saturated", 64'(stallCount), 64'd15);
      idle(); idle();

      // Scoreboard: reserve, write clears at the bank write edge
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
      check("busy_reserve7", 64'(busy), 64'h80);
      step(1'b0, '0, '0, 1'b1, 5'd7, 32'h77, 1'b0, '0);
      check("busy_before_clear", 64'(busy), 64'h80);
      idle();
      check("busy_cleared", 64'(busy), 64'h0);
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
      step(1'b0, '0, '0, 1'b1, 5'd7, 32'h78, 1'b0, '0);
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
      check("busy_set_wins", 64'(busy), 64'h80);
      check("conflict_not_set", 64'(conflict), 64'd0);

      // Conflict: double reservation without an intervening write
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd3);
      check("conflict_first", 64'(conflict), 64'd0);
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd3);
      check("conflict_set", 64'(conflict), 64'd1);
      check("busy_3_7", 64'(busy), 64'h88);
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd0);
      check("busy_reserve0", 64'(busy), 64'h88);
      idle();
      check("conflict_sticky", 64'(conflict), 64'd1);

      // Reset mid-operation while a write is on the bank port
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd4);
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd5);
      check("busy_before_reset", 64'(busy), 64'hB8);
      step(1'b1, 5'd6, 32'h66, 1'b0, '0, '0, 1'b0, '0);
      @(negedge clk);
      #1;
      check("pre_reset_regWrite", 64'(regWrite), 64'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_regWrite",  64'(regWrite),   64'd0);
      check("mid_rst_writeAddr", 64'(writeAddr),  64'd0);
      check("mid_rst_writeData", 64'(writeData),  64'd0);
      check("mid_rst_busy",      64'(busy),       64'd0);
      check("mid_rst_conflict",  64'(conflict),   64'd0);
      check("mid_rst_stall",     64'(stallCount), 64'd0);
      reset = 1'b0;
      m_prio = 1'b0;
      m_stall = 0;
      req0Valid = 1'b1; req1Valid = 1'b1;
      #1;
      check("rst_prio_req0", 64'(req0Ready), 64'd1);
      check("rst_prio_req1", 64'(req1Ready), 64'd0);
      req0Valid = 1'b0; req1Valid = 1'b0;
      @(posedge clk); #1;

      idle(); idle(); idle();
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
